hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 78 +++++++
 tb/tb_hazard_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush control with dmem wait tracking, timeout halt and stall counter
module hazard_unit #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ID_EX_memread,
    input  logic [4:0]       ID_EX_rd,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             IF_ID_use_rs1,
    input  logic             IF_ID_use_rs2,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state_o
);
    typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, HALT = 2'b10} state_e;

    state_e           state_q, state_d;
    logic [15:0]      wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             tmo_q, tmo_d;
    logic             load_use, mem_stall, run_like, expire;

    assign load_use  = ID_EX_memread && ID_EX_rd != 5'd0 &&
                       ((IF_ID_use_rs1 && IF_ID_rs1 == ID_EX_rd) ||
                        (IF_ID_use_rs2 && IF_ID_rs2 == ID_EX_rd));
    assign mem_stall = dmem_req && !dmem_ack;
    // An acked MEM_WAIT cycle behaves exactly like a RUN cycle for branch/load-use handling
    assign run_like  = (state_q == RUN && !mem_stall) || (state_q == MEM_WAIT && dmem_ack);
    assign expire    = state_q == MEM_WAIT && !dmem_ack && wait_q == 16'(MEM_TIMEOUT);

    assign pc_write     = !rst_n || (run_like && (branch_taken || !load_use));
    assign if_id_write  = pc_write;
    assign id_ex_write  = !rst_n || run_like;
    assign ex_mem_write = id_ex_write;
    assign mem_wb_write = id_ex_write;
    assign if_id_flush  = rst_n && run_like && branch_taken;
    assign id_ex_bubble = rst_n && run_like && (branch_taken || load_use);
    assign halted       = state_q == HALT;
    assign mem_timeout  = tmo_q;
    assign stall_cnt    = stall_q;
    assign state_o      = state_q;

    always_comb begin
        state_d = state_q == RUN      ? (mem_stall ? MEM_WAIT : RUN) :
                  state_q == MEM_WAIT ? (dmem_ack ? RUN : (expire ? HALT : MEM_WAIT)) : HALT;
        wait_d  = state_q == MEM_WAIT ? wait_q + 16'd1 : 16'd0;
        tmo_d   = tmo_q || expire;
        stall_d = (!pc_write && stall_q != {CNT_W{1'b1}}) ? stall_q + CNT_W'(1) : stall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wait_q  <= 16'd0;
            stall_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            tmo_q   <= tmo_d;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scoreboard bench for hazard_unit
module tb_hazard_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic memread, use1, use2, br, req, ack;
    logic [4:0] rd, rs1, rs2;
    logic pcw, ifw, idw, exw, mww, flush, bub, halted, tmo;
    logic [15:0] scnt;
    logic [1:0] st;
    logic b_memread, b_use1;
    logic [4:0] b_rd, b_rs1;
    logic [3:0] scnt2;
    logic b_pcw, b_ifw, b_idw, b_exw, b_mww, b_flush, b_bub, b_halted, b_tmo;
    logic [1:0] b_st;
    logic [9:0] sb[$];
    int errors = 0;
    int checks = 0;

    localparam logic [9:0] ALL  = 10'b11111_00_0_00;
    localparam logic [9:0] LU   = 10'b00111_01_0_00;
    localparam logic [9:0] BR   = 10'b11111_11_0_00;
    localparam logic [9:0] FRZ  = 10'b00000_00_0_00;
    localparam logic [9:0] FRZW = 10'b00000_00_0_01;
    localparam logic [9:0] ACKW = 10'b11111_00_0_01;
    localparam logic [9:0] ACKB = 10'b11111_11_0_01;
    localparam logic [9:0] HLT  = 10'b00000_00_1_10;

    always #5 clk = ~clk;

    hazard_unit #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ID_EX_memread(memread), .ID_EX_rd(rd),
        .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .IF_ID_use_rs1(use1), .IF_ID_use_rs2(use2),
        .branch_taken(br), .dmem_req(req), .dmem_ack(ack),
        .pc_write(pcw), .if_id_write(ifw), .id_ex_write(idw), .ex_mem_write(exw),
        .mem_wb_write(mww), .if_id_flush(flush), .id_ex_bubble(bub),
        .halted(halted), .mem_timeout(tmo), .stall_cnt(scnt), .state_o(st));

    hazard_unit #(.MEM_TIMEOUT(255), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .ID_EX_memread(b_memread), .ID_EX_rd(b_rd),
        .IF_ID_rs1(b_rs1), .IF_ID_rs2(5'd0), .IF_ID_use_rs1(b_use1), .IF_ID_use_rs2(1'b0),
        .branch_taken(1'b0), .dmem_req(1'b0), .dmem_ack(1'b0),
        .pc_write(b_pcw), .if_id_write(b_ifw), .id_ex_write(b_idw), .ex_mem_write(b_exw),
        .mem_wb_write(b_mww), .if_id_flush(b_flush), .id_ex_bubble(b_bub),
        .halted(b_halted), .mem_timeout(b_tmo), .stall_cnt(scnt2), .state_o(b_st));

    task automatic set(input logic m, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic u1, input logic u2, input logic b, input logic rq, input logic ak);
        memread = m; rd = d; rs1 = s1; rs2 = s2; use1 = u1; use2 = u2; br = b; req = rq; ack = ak;
    endtask

    task automatic pop_check(input string tag);
        logic [9:0] exp, obs;
        exp = sb.pop_front();
        obs = {pcw, ifw, idw, exw, mww, flush, bub, halted, st};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic m, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic u1, input logic u2, input logic b, input logic rq, input logic ak,
                        input logic [9:0] exp, input string tag);
        @(negedge clk);
        set(m, d, s1, s2, u1, u2, b, rq, ak);
        sb.push_back(exp);
        #1 pop_check(tag);
    endtask

    task automatic chk(input int obs, input int exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        b_memread = 1'b0; b_rd = 5'd0; b_rs1 = 5'd0; b_use1 = 1'b0;
        set(1, 5, 0, 5, 0, 1, 0, 0, 0);
        sb.push_back(ALL);
        #1 pop_check("reset_outputs");
        chk(scnt, 0, "reset_stall_cnt");
        chk(tmo, 0, "reset_timeout");
        @(negedge clk);
        set(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, ALL, "idle");
        chk(scnt, 0, "idle_stall_cnt");
        step(1, 5, 0, 5, 0, 1, 0, 0, 0, LU, "load_use_rs2");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, ALL, "after_load_use");
        chk(scnt, 1, "load_use_stall_cnt");
        step(1, 7, 7, 0, 1, 0, 0, 0, 0, LU, "load_use_rs1");
        step(1, 0, 0, 0, 1, 1, 0, 0, 0, ALL, "rd_zero_no_stall");
        step(1, 5, 0, 5, 0, 0, 0, 0, 0, ALL, "use_rs2_off_no_stall");
        step(1, 5, 5, 6, 0, 1, 0, 0, 0, ALL, "rs_mismatch_no_stall");
        step(1, 5, 0, 5, 0, 1, 1, 0, 0, BR, "branch_over_load_use");
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, BR, "branch_only");
        chk(scnt, 2, "branch_no_stall_count");

        step(1, 5, 0, 5, 0, 1, 1, 1, 0, FRZ, "mem_stall_priority");
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZW, "mem_wait_1");
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZW, "mem_wait_2");
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, ACKW, "mem_ack");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, ALL, "run_after_ack");
        chk(scnt, 5, "mem_wait_stall_cnt");
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, "mem_stall_2");
        step(0, 0, 0, 0, 0, 0, 1, 1, 1, ACKB, "ack_with_branch");
        step(1, 3, 3, 0, 1, 0, 0, 0, 0, LU, "load_use_after_ack");

        @(negedge clk);
        set(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 20 && st != 2'b10; i++) @(negedge clk);
        chk(st, 2, "timeout_reaches_halt");
        chk(tmo, 1, "timeout_flag");
        chk(halted, 1, "halted_flag");
        step(0, 0, 0, 0, 0, 0, 1, 1, 1, HLT, "halt_ignores_ack");
        step(1, 5, 5, 0, 1, 0, 0, 0, 0, HLT, "halt_ignores_inputs");
        chk(tmo, 1, "timeout_sticky");
        #1 rst_n = 1'b0;
        sb.push_back(ALL);
        #1 pop_check("async_reset_in_halt");
        chk(scnt, 0, "async_reset_stall_cnt");
        chk(tmo, 0, "async_reset_timeout");
        set(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, ALL, "run_after_reset");
        chk(scnt, 0, "stall_cnt_after_reset");

        @(negedge clk);
        b_memread = 1'b1; b_rd = 5'd9; b_rs1 = 5'd9; b_use1 = 1'b1;
        repeat (15) @(negedge clk);
        chk(scnt2, 15, "sat_reach_15");
        repeat (5) @(negedge clk);
        chk(scnt2, 15, "sat_hold_15");
        b_memread = 1'b0;
        @(negedge clk);
        chk(scnt2, 15, "sat_no_wrap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
